// File: rtl/tinyalu_arbiter.sv
// tinyalu_arbiter: round-robin arbiter/sequencer sharing one TinyALU.
// Ports: clk/reset, req/req_A/req_B/req_op in, ack/rsp_* out, busy, alu_* pins.
module tinyalu_arbiter #(
  parameter int N_REQ   = 4,
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] req_A,
  input  logic [8*N_REQ-1:0] req_B,
  input  logic [3*N_REQ-1:0] req_op,
  output logic [N_REQ-1:0]   ack,
  output logic [N_REQ-1:0]   rsp_valid,
  output logic [15:0]        rsp_result,
  output logic               rsp_err,
  output logic               busy,
  output logic               alu_start,
  output logic [7:0]         alu_A,
  output logic [7:0]         alu_B,
  output logic [2:0]         alu_op,
  input  logic               alu_done,
  input  logic [15:0]        alu_result
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [PW-1:0]    rr_ptr;
  logic [PW-1:0]    g_q;
  logic [PW-1:0]    gnt_idx;
  logic             any_req;
  logic [7:0]       a_q, b_q;
  logic [2:0]       op_q;
  logic [CW-1:0]    cnt;
  logic [15:0]      res_q;
  logic             err_q;
  logic [N_REQ-1:0] ack_q;

  logic [2:0] sel_op;
  logic       sel_alu;
  logic       timeout;

  // Walk downward so the lowest offset from rr_ptr wins.
  always_comb begin
    gnt_idx = '0;
    any_req = 1'b0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (req[(int'(rr_ptr) + k) % N_REQ]) begin
        gnt_idx = PW'((int'(rr_ptr) + k) % N_REQ);
        any_req = 1'b1;
      end
    end
  end

  assign sel_op  = req_op[3*int'(gnt_idx) +: 3];
  assign sel_alu = (sel_op != 3'd0) && (sel_op <= 3'd4);
  assign timeout = (cnt == CW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (any_req) state_nxt = sel_alu ? ISSUE : RESP;
      end
      ISSUE: begin
        if (alu_done || timeout) state_nxt = RESP;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr <= '0;
      g_q    <= '0;
      a_q    <= '0;
      b_q    <= '0;
      op_q   <= '0;
      cnt    <= '0;
      res_q  <= '0;
      err_q  <= 1'b0;
      ack_q  <= '0;
    end else begin
      ack_q <= '0;
      unique case (state)
        IDLE: begin
          if (any_req) begin
            g_q    <= gnt_idx;
            rr_ptr <= PW'((int'(gnt_idx) + 1) % N_REQ);
            ack_q  <= N_REQ'(1) << gnt_idx;
            a_q    <= req_A[8*int'(gnt_idx) +: 8];
            b_q    <= req_B[8*int'(gnt_idx) +: 8];
            op_q   <= sel_op;
            cnt    <= '0;
            res_q  <= '0;
            // Local ops resolve here: 000 is fine, 101..111 flag error.
            err_q  <= (sel_op > 3'd4);
          end
        end
        ISSUE: begin
          if (alu_done) begin
            res_q <= alu_result;
            err_q <= 1'b0;
          end else if (timeout) begin
            res_q <= '0;
            err_q <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Outputs decode only registered state, never live inputs.
  always_comb begin
    ack        = ack_q;
    rsp_valid  = '0;
    rsp_result = '0;
    rsp_err    = 1'b0;
    busy       = (state != IDLE);
    alu_start  = 1'b0;
    alu_A      = '0;
    alu_B      = '0;
    alu_op     = '0;
    unique case (state)
      ISSUE: begin
        alu_start = 1'b1;
        alu_A     = a_q;
        alu_B     = b_q;
        alu_op    = op_q;
      end
      RESP: begin
        rsp_valid  = N_REQ'(1) << g_q;
        rsp_result = res_q;
        rsp_err    = err_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_tinyalu_arbiter.sv
// tb_tinyalu_arbiter: randomized bench with a transaction-level model.
// Acts as requesters and TinyALU, checks grants, timing and results.
module tb_tinyalu_arbiter;

  localparam int N  = 4;
  localparam int TO = 15;

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req;
  logic [8*N-1:0] req_A, req_B;
  logic [3*N-1:0] req_op;
  logic [N-1:0]   ack, rsp_valid;
  logic [15:0]    rsp_result;
  logic           rsp_err, busy, alu_start;
  logic [7:0]     alu_A, alu_B;
  logic [2:0]     alu_op;
  logic           alu_done;
  logic [15:0]    alu_result;

  int n_tests = 0;
  int n_fail  = 0;
  int rr      = 0;

  logic [7:0] ma [N];
  logic [7:0] mb [N];
  logic [2:0] mo [N];

  always #5 clk = ~clk;

  tinyalu_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .req(req), .req_A(req_A), .req_B(req_B), .req_op(req_op),
    .ack(ack), .rsp_valid(rsp_valid),
    .rsp_result(rsp_result), .rsp_err(rsp_err), .busy(busy),
    .alu_start(alu_start), .alu_A(alu_A), .alu_B(alu_B),
    .alu_op(alu_op), .alu_done(alu_done), .alu_result(alu_result)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [15:0] alu_ref(input logic [2:0] op,
                                          input logic [7:0] a,
                                          input logic [7:0] b);
    case (op)
      3'd1:    return 16'(a) + 16'(b);
      3'd2:    return 16'(a & b);
      3'd3:    return 16'(a ^ b);
      3'd4:    return 16'(a) * 16'(b);
      default: return 16'h0;
    endcase
  endfunction

  function automatic int pick(input logic [N-1:0] m);
    for (int k = 0; k < N; k++)
      if (m[(rr + k) % N]) return (rr + k) % N;
    return -1;
  endfunction

  task automatic drive_ops();
    for (int i = 0; i < N; i++) begin
      req_A[8*i +: 8]  = ma[i];
      req_B[8*i +: 8]  = mb[i];
      req_op[3*i +: 3] = mo[i];
    end
  endtask

  task automatic post(input int i, input logic [2:0] op,
                      input logic [7:0] a, input logic [7:0] b);
    ma[i]  = a;
    mb[i]  = b;
    mo[i]  = op;
    req[i] = 1'b1;
    drive_ops();
  endtask

  task automatic all_zero(input string tag);
    chk(tag, {ack, rsp_valid, rsp_result, rsp_err, busy,
              alu_start, alu_A, alu_B, alu_op}, 32'h0);
  endtask

  // Called during an IDLE cycle with req nonzero; ends in the next IDLE.
  // dly: ISSUE cycle in which the ALU raises done (> TO never).
  task automatic txn(input int dly);
    int         g;
    int         last;
    logic [N-1:0] oh;
    logic [2:0] op;
    logic [7:0] a, b;
    logic [15:0] exp_res;
    g  = pick(req);
    oh = N'(1) << g;
    op = mo[g];
    a  = ma[g];
    b  = mb[g];
    tick();
    req[g] = 1'b0;
    chk("ack", 32'(ack), 32'(oh));
    chk("busy", 32'(busy), 32'd1);
    rr = (g + 1) % N;
    if (op == 3'd0 || op > 3'd4) begin
      chk("loc_rsp", 32'(rsp_valid), 32'(oh));
      chk("loc_res", 32'(rsp_result), 32'd0);
      chk("loc_err", 32'(rsp_err), 32'(op != 3'd0));
      chk("loc_start", 32'(alu_start), 32'd0);
      alu_done   = 1'($urandom_range(0, 1));
      alu_result = 16'($urandom);
    end else begin
      last = (dly <= TO) ? dly : TO;
      exp_res = (dly <= TO) ? alu_ref(op, a, b) : 16'h0;
      for (int c = 1; c <= last; c++) begin
        chk("start", 32'(alu_start), 32'd1);
        chk("opA", 32'(alu_A), 32'(a));
        chk("opB", 32'(alu_B), 32'(b));
        chk("opc", 32'(alu_op), 32'(op));
        chk("early_rsp", 32'(rsp_valid), 32'd0);
        alu_done   = (c == dly);
        alu_result = (c == dly) ? alu_ref(op, a, b) : 16'($urandom);
        tick();
        alu_done = 1'b0;
      end
      chk("rsp", 32'(rsp_valid), 32'(oh));
      chk("res", 32'(rsp_result), 32'(exp_res));
      chk("err", 32'(rsp_err), 32'(dly > TO));
      chk("start_off", 32'(alu_start), 32'd0);
      chk("opA_off", 32'(alu_A), 32'd0);
      chk("ack_off", 32'(ack), 32'd0);
    end
    tick();
    alu_done = 1'b0;
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_rsp", 32'(rsp_valid), 32'd0);
    chk("idle_start", 32'(alu_start), 32'd0);
  endtask

  initial begin
    int r, d;
    reset      = 1'b1;
    req        = '0;
    req_A      = '0;
    req_B      = '0;
    req_op     = '0;
    alu_done   = 1'b0;
    alu_result = '0;
    for (int i = 0; i < N; i++) begin
      ma[i] = '0;
      mb[i] = '0;
      mo[i] = '0;
    end
    tick();
    tick();
    reset = 1'b0;
    all_zero("reset_state");
    rr = 0;

    // Contention: everyone keeps requesting, expect 0,1,2,3,0.
    for (int i = 0; i < N; i++) post(i, 3'd1, 8'(i), 8'(i + 1));
    for (int t = 0; t < 5; t++) begin
      chk("rr_order", 32'(pick(req)), 32'(t % N));
      r = pick(req);
      txn(2);
      post(r, 3'd1, 8'($urandom), 8'($urandom));
    end
    req = '0;
    tick();

    reset = 1'b1;
    tick();
    reset = 1'b0;
    rr = 0;

    post(0, 3'd1, 8'h12, 8'h34);
    txn(1);
    post(2, 3'd4, 8'hFF, 8'hFF);
    txn(3);
    post(1, 3'd3, 8'hA5, 8'h0F);
    txn(100);
    post(3, 3'd0, 8'h55, 8'h66);
    txn(1);
    post(0, 3'd6, 8'h77, 8'h88);
    txn(1);
    post(1, 3'd2, 8'hF0, 8'h3C);
    txn(TO);

    // Reset in the middle of a multiply.
    post(2, 3'd4, 8'h10, 8'h20);
    tick();
    req = '0;
    chk("rst_ack", 32'(ack), 32'b0100);
    tick();
    chk("rst_issue", 32'(alu_start), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    all_zero("rst_mid");
    rr = 0;
    alu_done   = 1'b1;
    alu_result = 16'hBEEF;
    tick();
    alu_done = 1'b0;
    chk("stray_done", 32'({rsp_valid, busy, alu_start}), 32'd0);
    tick();
    chk("stray_done2", 32'({rsp_valid, busy}), 32'd0);
    post(3, 3'd1, 8'h01, 8'h02);
    post(1, 3'd1, 8'h03, 8'h04);
    chk("post_rst_pick", 32'(pick(req)), 32'd1);
    txn(2);
    txn(1);

    // Randomized traffic with requesters left pending across grants.
    for (int t = 0; t < 60; t++) begin
      for (int i = 0; i < N; i++)
        if (!req[i] && ($urandom_range(0, 2) == 0))
          post(i, 3'($urandom), 8'($urandom), 8'($urandom));
      if (req == '0)
        post($urandom_range(0, N - 1), 3'($urandom),
             8'($urandom), 8'($urandom));
      r = $urandom_range(0, 7);
      if (r == 0)      d = TO;
      else if (r == 1) d = TO + 2;
      else             d = $urandom_range(1, 6);
      txn(d);
    end
    req = '0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
